// File: rtl/prl_pkg.sv
// Shared definitions for the USB-PD protocol-layer transmit path:
// one-hot state encoding, TCPCI ALERT bit positions and retry limits.
package prl_pkg;

  // One-hot transmit states; the enum constants double as the state localparams
  typedef enum logic [9:0] {
    IDLE            = 10'b00_0000_0001,
    WAIT_FOR_REQ    = 10'b00_0000_0010,
    CONSTRUCT       = 10'b00_0000_0100,
    WAIT_PHY        = 10'b00_0000_1000,
    MATCH_ID        = 10'b00_0001_0000,
    CHECK_RETRY     = 10'b00_0010_0000,
    SENT            = 10'b00_0100_0000,
    TX_ERROR        = 10'b00_1000_0000,
    DISCARD         = 10'b01_0000_0000,
    PHY_LAYER_RESET = 10'b10_0000_0000
  } prl_state_t;

  // TCPCI ALERT register bit positions
  localparam int RX_SOP       = 2;
  localparam int TX_FAILED    = 4;
  localparam int TX_DISCARDED = 5;
  localparam int TX_SUCCESS   = 6;

  // Hard cap on the number of retries after the first attempt
  localparam int nRetryCount = 3;

  // Clamp the requested retry count to the hard cap
  function automatic logic [1:0] clip_retry(input logic [1:0] req, input int cap);
    if (int'(req) > cap) return 2'(cap);
    return req;
  endfunction

endpackage

// File: rtl/prl_crc_timer.sv
// CRCReceiveTimer: cleared while idle, started by PHY_Tx_Done, then counts
// every cycle; expired flags the cycle the count reaches LIMIT-1.
module prl_crc_timer #(
  parameter int TIMER_W = 16,
  parameter int LIMIT   = 900
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic expired
);

  logic [TIMER_W-1:0] count;
  logic               run;

  // Counter: clear dominates, a start while already running is ignored
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
      run   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      run   <= 1'b0;
    end else if (start && !run) begin
      count <= '0;
      run   <= 1'b1;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/prl_tx_module.sv
// USB-PD protocol-layer transmit state machine. Hands a requested message to
// the PHY, waits for GoodCRC with retry/timeout, discards on an incoming
// message, maintains MessageIDCounter and reports through TCPCI ALERT bits.
// Optional: define PRL_TX_MSGID_CHECK_EN to make MATCH_ID compare the
// GoodCRC MessageID; otherwise any GoodCRC counts as success.
module prl_tx_module
  import prl_pkg::*;
#(
  parameter int CRC_TIMEOUT = 900,
  parameter int TIMER_W     = 16,
  parameter int MAX_RETRY   = nRetryCount
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        Start,
  input  logic        cableReset,
  input  logic        hardReset,
  input  logic        Tx_Req,
  input  logic [1:0]  Tx_Retry_Count,
  input  logic [7:0]  Tx_Byte_Count,
  input  logic        Msg_Received,
  input  logic        PHY_Tx_Done,
  input  logic        PHY_Tx_Fail,
  input  logic        GoodCRC_Received,
  input  logic [2:0]  GoodCRC_MsgID,
  input  logic [15:0] ALERT_Clear,
  output logic        PHY_Tx_Start,
  output logic [2:0]  TX_MessageID,
  output logic [7:0]  TX_BYTE_COUNT,
  output logic        Tx_State_Machine_ACTIVE,
  output logic [15:0] ALERT
);

  prl_state_t  state, next_state;
  logic [1:0]  retry_cnt, retry_lim;
  logic        phy_reset;
  logic        timer_expired;
  logic        id_match;
  logic        next_active;
  logic [15:0] set_bits;
  logic        latch_req, msgid_inc, msgid_clr, retry_inc, retry_clr;

  assign phy_reset = cableReset | hardReset;

  prl_crc_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (CRC_TIMEOUT)
  ) u_crc_timer (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (state != WAIT_PHY),
    .start   ((state == WAIT_PHY) && PHY_Tx_Done),
    .expired (timer_expired)
  );

`ifdef PRL_TX_MSGID_CHECK_EN
  logic [2:0] crc_msg_id;

  // Hold the GoodCRC MessageID so MATCH_ID sees it after the strobe drops
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) crc_msg_id <= '0;
    else if ((state == WAIT_PHY) && GoodCRC_Received) crc_msg_id <= GoodCRC_MsgID;
  end

  assign id_match = (crc_msg_id == TX_MessageID);
`else
  logic unused_msg_id;
  assign unused_msg_id = ^GoodCRC_MsgID;
  assign id_match      = 1'b1;
`endif

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-state actions; PHY reset overrides everything but IDLE
  always_comb begin
    next_state = state;
    set_bits   = '0;
    latch_req  = 1'b0;
    msgid_inc  = 1'b0;
    msgid_clr  = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    unique case (state)
      IDLE:         if (Start || phy_reset) next_state = WAIT_FOR_REQ;
      WAIT_FOR_REQ: if (Tx_Req) begin
                      next_state = CONSTRUCT;
                      latch_req  = 1'b1;
                    end
      CONSTRUCT:    next_state = WAIT_PHY;
      WAIT_PHY:     if (Msg_Received)          next_state = DISCARD;
                    else if (PHY_Tx_Fail)      next_state = CHECK_RETRY;
                    else if (GoodCRC_Received) next_state = MATCH_ID;
                    else if (timer_expired)    next_state = CHECK_RETRY;
      MATCH_ID:     next_state = id_match ? SENT : CHECK_RETRY;
      CHECK_RETRY:  if (retry_cnt < retry_lim) begin
                      retry_inc  = 1'b1;
                      next_state = CONSTRUCT;
                    end else begin
                      next_state = TX_ERROR;
                    end
      SENT: begin
        set_bits[TX_SUCCESS] = 1'b1;
        msgid_inc  = 1'b1;
        retry_clr  = 1'b1;
        next_state = WAIT_FOR_REQ;
      end
      TX_ERROR: begin
        set_bits[TX_FAILED] = 1'b1;
        msgid_inc  = 1'b1;
        retry_clr  = 1'b1;
        next_state = WAIT_FOR_REQ;
      end
      DISCARD: begin
        set_bits[TX_DISCARDED] = 1'b1;
        msgid_inc  = 1'b1;
        retry_clr  = 1'b1;
        next_state = WAIT_FOR_REQ;
      end
      PHY_LAYER_RESET: next_state = WAIT_FOR_REQ;
      default:         next_state = IDLE;
    endcase
    if (phy_reset && (state != IDLE)) begin
      next_state = PHY_LAYER_RESET;
      set_bits   = '0;
      latch_req  = 1'b0;
      msgid_inc  = 1'b0;
      retry_inc  = 1'b0;
      msgid_clr  = 1'b1;
      retry_clr  = 1'b1;
    end
    next_active = next_state inside {CONSTRUCT, WAIT_PHY, MATCH_ID, CHECK_RETRY,
                                     SENT, TX_ERROR, DISCARD};
  end

  // Registered outputs, counters and the ALERT set/clear register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      PHY_Tx_Start            <= 1'b0;
      TX_MessageID            <= '0;
      TX_BYTE_COUNT           <= '0;
      Tx_State_Machine_ACTIVE <= 1'b0;
      ALERT                   <= '0;
      retry_cnt               <= '0;
      retry_lim               <= '0;
    end else begin
      PHY_Tx_Start            <= (next_state == CONSTRUCT);
      Tx_State_Machine_ACTIVE <= next_active;
      ALERT                   <= (ALERT & ~ALERT_Clear) | set_bits;
      if (msgid_clr)      TX_MessageID <= '0;
      else if (msgid_inc) TX_MessageID <= TX_MessageID + 3'd1;
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
      if (latch_req) begin
        TX_BYTE_COUNT <= Tx_Byte_Count;
        retry_lim     <= clip_retry(Tx_Retry_Count, MAX_RETRY);
      end
    end
  end

endmodule
